// File: rtl/implication_pkg.sv
// Shared types and helpers for the implication responder.
// Contents:
//   resp_state_t - status FSM encoding (IDLE / BACKLOG / OVERFLOW)
//   DEPTH_MAX    - largest supported queue depth
//   pend_w()     - width needed to hold a count of 0..depth
package implication_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BACKLOG  = 2'd1,
    OVERFLOW = 2'd2
  } resp_state_t;

  localparam int DEPTH_MAX = 255;

  function automatic int pend_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/implication_responder_pend_counter.sv
// pend_counter: saturating up/down counter of queued requests.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   inc   in  add one request
//   dec   in  remove one request
//   count out current count (0..MAX)
//   full  out count == MAX
//   empty out count == 0
//   drop  out an increment was refused because the counter is full
module pend_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  logic [W-1:0] r_count;
  logic         w_full;
  logic         w_empty;

  assign w_full  = (r_count == W'(MAX));
  assign w_empty = (r_count == '0);

  // Simultaneous inc and dec cancel out, which is what lets a full queue
  // accept a new request in the same cycle it drains one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !dec && !w_full) begin
      r_count <= r_count + 1'b1;
    end else if (dec && !inc && !w_empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;
  assign drop  = inc && !dec && w_full;

endmodule

// File: rtl/implication_responder.sv
// implication_responder: target side of the A |=> B handshake. Every sampled
// req_a produces exactly one ack_b pulse; with hold low and nothing queued the
// ack follows one clock later, otherwise requests queue (up to DEPTH) and
// drain one per cycle once hold drops.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   req_a    in  request, one per high cycle
//   hold     in  backpressure, no ack may issue while high
//   clr_ovf  in  clears sticky ovf (a same-cycle drop takes priority)
//   ack_b    out registered acknowledge pulse
//   pend     out queued, not yet acknowledged requests
//   ovf      out sticky: a request was dropped because the queue was full
//   ack_cnt  out wrapping count of acks since reset
// Optional build macro IMPLICATION_RESPONDER_SVA_EN embeds protocol assertions
// and a cover on the drop event; behaviour is identical without it.
module implication_responder
  import implication_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_a,
  input  logic                       hold,
  input  logic                       clr_ovf,
  output logic                       ack_b,
  output logic [pend_w(DEPTH)-1:0]   pend,
  output logic                       ovf,
  output logic [CNT_W-1:0]           ack_cnt
);

  localparam int PEND_W = pend_w(DEPTH);

  logic              r_ack_b;
  logic [CNT_W-1:0]  r_ack_cnt;
  logic              r_ovf;
  resp_state_t       r_state;
  resp_state_t       w_state_next;

  logic [PEND_W-1:0] w_pend;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic              w_issue;
  logic              w_accept;
  logic              w_dec;
  logic              w_ovf_next;
  logic              w_pend_next_nz;

  // Queue drains first: a fresh request only bypasses the queue when it is
  // empty, so at most one ack per cycle and order is preserved.
  assign w_issue  = !hold && (req_a || !w_empty);
  assign w_dec    = w_issue && !w_empty;
  assign w_accept = req_a && !(w_issue && w_empty);

  pend_counter #(
    .MAX (DEPTH),
    .W   (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_accept),
    .dec   (w_dec),
    .count (w_pend),
    .full  (w_full),
    .empty (w_empty),
    .drop  (w_drop)
  );

  assign w_ovf_next = w_drop ? 1'b1 : (clr_ovf ? 1'b0 : r_ovf);

  // Whether pend is non-zero after this edge; drives the status FSM so the
  // state reflects post-update values.
  always_comb begin
    w_pend_next_nz = !w_empty;
    if (w_accept && !w_dec && !w_full) begin
      w_pend_next_nz = 1'b1;
    end else if (w_dec && !w_accept && (w_pend == PEND_W'(1))) begin
      w_pend_next_nz = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_b   <= 1'b0;
      r_ack_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ack_b   <= w_issue;
      r_ack_cnt <= r_ack_cnt + CNT_W'(w_issue);
      r_ovf     <= w_ovf_next;
    end
  end

  // Status FSM: purely observational, never gates acking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, BACKLOG: begin
        if (w_drop) begin
          w_state_next = OVERFLOW;
        end else begin
          w_state_next = w_pend_next_nz ? BACKLOG : IDLE;
        end
      end
      OVERFLOW: begin
        if (clr_ovf && !w_drop) begin
          w_state_next = w_pend_next_nz ? BACKLOG : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign ack_b   = r_ack_b;
  assign pend    = w_pend;
  assign ovf     = r_ovf;
  assign ack_cnt = r_ack_cnt;

`ifdef IMPLICATION_RESPONDER_SVA_EN
  a_next_cycle_ack: assert property (@(posedge clk) disable iff (rst)
    (req_a && !hold && (pend == '0)) |=> ack_b)
    else $display("%0t: ack_b missing one cycle after unqueued request", $time);

  a_ack_has_source: assert property (@(posedge clk) disable iff (rst)
    ack_b |-> $past((pend != '0) || req_a))
    else $display("%0t: ack_b without a queued or fresh request", $time);

  a_pend_bound: assert property (@(posedge clk) disable iff (rst)
    pend <= PEND_W'(DEPTH))
    else $display("%0t: pend exceeds DEPTH", $time);

  c_drop: cover property (@(posedge clk) disable iff (rst) w_drop);
`else
  // Assertions compiled out.
`endif

endmodule
